// File: rtl/song_pkg.sv
`default_nettype none
// ============================================================================
//  Module : song_pkg
//  Brief  : Song byte format and state encodings shared by recorder and player.
//  Rev    : 1.0 - initial release
// ============================================================================
package song_pkg;

  localparam int DUR_W  = 4;
  localparam int TONE_W = 4;
  localparam int NOTE_W = DUR_W + TONE_W;

  // Duration field of zero marks the end of a song.
  localparam logic [NOTE_W-1:0] END_BYTE  = '0;
  localparam logic [TONE_W-1:0] TONE_REST = '0;

  typedef logic [1:0] rec_state_t;
  localparam rec_state_t ST_IDLE  = 2'd0;
  localparam rec_state_t ST_REC   = 2'd1;
  localparam rec_state_t ST_FLUSH = 2'd2;
  localparam rec_state_t ST_TERM  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/song_recorder.sv
`default_nettype none
// ============================================================================
//  Module : song_recorder
//  Brief  : Captures live tone/tick input as {dur,tone} note bytes for song RAM.
//  Rev    : 1.0 - initial release
// ============================================================================
module song_recorder
  import song_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [TONE_W-1:0] tone_in,
  input  logic              rec_start,
  input  logic              rec_stop,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [NOTE_W-1:0] wr_data,
  output logic              recording,
  output logic              full,
  output logic [ADDR_W-1:0] note_count
);

  localparam logic [DUR_W-1:0]  DUR_MAX   = '1;
  localparam logic [DUR_W-1:0]  DUR_SPLIT = DUR_MAX - DUR_W'(1);
  // Top address is kept for the terminator, so the last note lands one below.
  localparam logic [ADDR_W-1:0] ADDR_LAST_NOTE = {{(ADDR_W-1){1'b1}}, 1'b0};

  rec_state_t          state_q, state_d;
  logic [TONE_W-1:0]   cur_tone_q, cur_tone_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [NOTE_W-1:0]   wr_data_q, wr_data_d;
  logic                recording_q, recording_d;
  logic                full_q, full_d;
  logic [ADDR_W-1:0]   note_count_q, note_count_d;

  logic                note_wr;
  logic [DUR_W-1:0]    note_dur;
  logic [DUR_W-1:0]    tick_cnt;

  assign tick_cnt = {{(DUR_W-1){1'b0}}, tick};

  always_comb begin
    state_d      = state_q;
    cur_tone_d   = cur_tone_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    full_d       = full_q;
    note_count_d = note_count_q;
    note_wr      = 1'b0;
    note_dur     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (rec_start) begin
          state_d      = ST_REC;
          addr_d       = '0;
          note_count_d = '0;
          full_d       = 1'b0;
          cur_tone_d   = tone_in;
          cnt_d        = '0;
        end
      end
      ST_REC: begin
        if (rec_stop) begin
          state_d = ST_FLUSH;
        end else if (tone_in != cur_tone_q) begin
          // A change before any tick is a selection glitch and is not stored.
          note_wr    = (cnt_q != '0);
          cur_tone_d = tone_in;
          cnt_d      = tick_cnt;
        end else if (tick && (cnt_q == DUR_SPLIT)) begin
          note_wr  = 1'b1;
          note_dur = DUR_MAX;
          cnt_d    = '0;
        end else if (tick) begin
          cnt_d = cnt_q + DUR_W'(1);
        end
      end
      ST_FLUSH: begin
        note_wr = (cnt_q != '0);
        cnt_d   = '0;
        state_d = ST_TERM;
      end
      ST_TERM: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = END_BYTE;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (note_wr) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = addr_q;
      wr_data_d    = {note_dur, cur_tone_q};
      addr_d       = addr_q + ADDR_W'(1);
      note_count_d = note_count_q + ADDR_W'(1);
      if (addr_q == ADDR_LAST_NOTE) begin
        full_d  = 1'b1;
        state_d = ST_TERM;
      end
    end

    recording_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_tone_q   <= TONE_REST;
      cnt_q        <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      recording_q  <= 1'b0;
      full_q       <= 1'b0;
      note_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_tone_q   <= cur_tone_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      recording_q  <= recording_d;
      full_q       <= full_d;
      note_count_q <= note_count_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign recording  = recording_q;
  assign full       = full_q;
  assign note_count = note_count_q;

endmodule
`default_nettype wire

// File: tb/tb_song_recorder.sv
`default_nettype none
// ============================================================================
//  Module : tb_song_recorder
//  Brief  : Drives a large and a tiny recorder in parallel against a take model.
//  Rev    : 1.0 - initial release
// ============================================================================
module tb_song_recorder;
  import song_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rec_start = 1'b0;
  logic       rec_stop = 1'b0;
  logic [3:0] tone_in = 4'd0;

  logic       we_b, rec_b, full_b;
  logic [7:0] wa_b, wd_b, nc_b;
  logic       we_s, rec_s, full_s;
  logic [2:0] wa_s, nc_s;
  logic [7:0] wd_s;

  int n_cmp = 0;
  int n_bad = 0;

  // Take model: a take is a list of (tone, ticks) segments, each becoming
  // 15-tick chunks plus a remainder byte, truncated to the note capacity.
  int         cap [2] = '{255, 7};
  bit         m_active [2];
  int         m_busy [2];
  int         m_tone [2];
  int         m_len [2];
  int         m_n [2];
  bit         m_rec [2];
  logic [7:0] m_exp [2][256];

  int         cap_n [2];
  int         cap_addr [2][512];
  logic [7:0] cap_data [2][512];

  song_recorder #(.ADDR_W(8)) dut_big (
    .clk(clk), .rst(rst), .tick(tick), .tone_in(tone_in),
    .rec_start(rec_start), .rec_stop(rec_stop),
    .wr_en(we_b), .wr_addr(wa_b), .wr_data(wd_b),
    .recording(rec_b), .full(full_b), .note_count(nc_b)
  );

  song_recorder #(.ADDR_W(3)) dut_small (
    .clk(clk), .rst(rst), .tick(tick), .tone_in(tone_in),
    .rec_start(rec_start), .rec_stop(rec_stop),
    .wr_en(we_s), .wr_addr(wa_s), .wr_data(wd_s),
    .recording(rec_s), .full(full_s), .note_count(nc_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic get_outs(input int d, output logic we, output logic [31:0] ad,
                          output logic [31:0] dt, output logic rc, output logic fl,
                          output logic [31:0] nc);
    if (d == 0) begin
      we = we_b; ad = {24'd0, wa_b}; dt = {24'd0, wd_b};
      rc = rec_b; fl = full_b; nc = {24'd0, nc_b};
    end else begin
      we = we_s; ad = {29'd0, wa_s}; dt = {24'd0, wd_s};
      rc = rec_s; fl = full_s; nc = {29'd0, nc_s};
    end
  endtask

  function automatic void append(input int d, input logic [7:0] b);
    if (m_n[d] < cap[d]) begin
      m_exp[d][m_n[d]] = b;
      m_n[d]++;
    end
  endfunction

  function automatic void close_seg(input int d);
    for (int k = 0; k < m_len[d] / 15; k++) append(d, {4'hF, 4'(m_tone[d])});
    if (m_len[d] % 15 != 0) append(d, {4'(m_len[d] % 15), 4'(m_tone[d])});
  endfunction

  function automatic void model_edge(input int d, input bit tk, input int tn,
                                     input bit st, input bit sp);
    int pre_busy;
    pre_busy = m_busy[d];
    if (m_busy[d] > 0) m_busy[d]--;
    if (!m_active[d]) begin
      if (st && pre_busy == 0) begin
        m_active[d] = 1'b1;
        m_tone[d]   = tn;
        m_len[d]    = 0;
        m_n[d]      = 0;
        cap_n[d]    = 0;
      end
    end else if (sp) begin
      close_seg(d);
      m_active[d] = 1'b0;
      m_busy[d]   = 2;
    end else begin
      if (tn != m_tone[d]) begin
        close_seg(d);
        m_tone[d] = tn;
        m_len[d]  = tk ? 1 : 0;
      end else begin
        m_len[d] += tk ? 1 : 0;
      end
      if (m_n[d] + m_len[d] / 15 >= cap[d]) begin
        for (int k = 0; k < m_len[d] / 15; k++) append(d, {4'hF, 4'(m_tone[d])});
        m_active[d] = 1'b0;
        m_busy[d]   = 1;
      end
    end
    m_rec[d] = m_active[d] || (m_busy[d] > 0);
  endfunction

  task automatic cyc(input bit tk, input int tn, input bit st, input bit sp);
    logic we, rc, fl;
    logic [31:0] ad, dt, nc;
    tick = tk; tone_in = 4'(tn); rec_start = st; rec_stop = sp;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d, tk, tn, st, sp);
    @(negedge clk);
    tick = 1'b0; rec_start = 1'b0; rec_stop = 1'b0;
    for (int d = 0; d < 2; d++) begin
      get_outs(d, we, ad, dt, rc, fl, nc);
      if (we === 1'b1 && cap_n[d] < 512) begin
        cap_addr[d][cap_n[d]] = int'(ad);
        cap_data[d][cap_n[d]] = dt[7:0];
        cap_n[d]++;
      end
      check($sformatf("recording.d%0d", d), {31'd0, rc}, {31'd0, m_rec[d]});
    end
  endtask

  task automatic idle(input int n, input int tn);
    repeat (n) cyc(1'b0, tn, 1'b0, 1'b0);
  endtask

  task automatic hold(input int tn, input int nticks, input int gap);
    repeat (nticks) begin
      idle(gap, tn);
      cyc(1'b1, tn, 1'b0, 1'b0);
    end
  endtask

  task automatic check_take(input string tag);
    logic we, rc, fl;
    logic [31:0] ad, dt, nc;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.d%0d.nwrites", tag, d), cap_n[d], m_n[d] + 1);
      for (int i = 0; i < cap_n[d] && i <= m_n[d]; i++) begin
        check($sformatf("%s.d%0d.addr%0d", tag, d, i), cap_addr[d][i], i);
        check($sformatf("%s.d%0d.data%0d", tag, d, i), {24'd0, cap_data[d][i]},
              (i < m_n[d]) ? {24'd0, m_exp[d][i]} : 32'd0);
      end
      get_outs(d, we, ad, dt, rc, fl, nc);
      check($sformatf("%s.d%0d.note_count", tag, d), nc, m_n[d]);
      check($sformatf("%s.d%0d.full", tag, d), {31'd0, fl}, {31'd0, m_n[d] == cap[d]});
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic we, rc, fl;
    logic [31:0] ad, dt, nc;
    for (int d = 0; d < 2; d++) begin
      get_outs(d, we, ad, dt, rc, fl, nc);
      check($sformatf("%s.d%0d.outs", tag, d),
            {we, rc, fl} | ad | dt | nc, 32'd0);
    end
  endtask

  initial begin
    int len;
    int tn;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2, 0);

    // T1: tone 3 for 5 ticks, tone 7 for 2 ticks
    cyc(1'b0, 3, 1'b1, 1'b0);
    hold(3, 5, 2);
    cyc(1'b0, 7, 1'b0, 1'b0);
    hold(7, 2, 2);
    cyc(1'b0, 7, 1'b0, 1'b1);
    idle(4, 7);
    check_take("T1");
    check("T1.lit0", {24'd0, cap_data[0][0]}, 32'h53);
    check("T1.lit1", {24'd0, cap_data[0][1]}, 32'h27);
    check("T1.lit2", {24'd0, cap_data[0][2]}, 32'h00);
    check("T1.count", {24'd0, nc_b}, 32'd2);

    // T2: 20 ticks of tone 9 split into 15 + 5
    cyc(1'b0, 9, 1'b1, 1'b0);
    hold(9, 20, 1);
    cyc(1'b0, 9, 1'b0, 1'b1);
    idle(4, 9);
    check_take("T2");
    check("T2.lit0", {24'd0, cap_data[0][0]}, 32'hF9);
    check("T2.lit1", {24'd0, cap_data[0][1]}, 32'h59);

    // T3: 3->4->3 glitch before any tick
    cyc(1'b0, 3, 1'b1, 1'b0);
    cyc(1'b0, 4, 1'b0, 1'b0);
    cyc(1'b0, 3, 1'b0, 1'b0);
    hold(3, 3, 1);
    cyc(1'b0, 3, 1'b0, 1'b1);
    idle(4, 3);
    check_take("T3");
    check("T3.lit0", {24'd0, cap_data[0][0]}, 32'h33);
    check("T3.nwr", cap_n[0], 2);

    // T4: 9 one-tick notes; tiny instance fills after 7; mid-take start ignored
    cyc(1'b0, 1, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      cyc(1'b0, (k % 2) + 1, (k == 3), 1'b0);
      cyc(1'b1, (k % 2) + 1, 1'b0, 1'b0);
    end
    cyc(1'b0, 1, 1'b0, 1'b1);
    idle(4, 1);
    check_take("T4");
    check("T4.small_nwr", cap_n[1], 8);
    check("T4.small_term", {24'd0, cap_data[1][7]}, 32'h00);
    check("T4.small_full", {31'd0, full_s}, 32'd1);
    check("T4.big_count", {24'd0, nc_b}, 32'd9);

    // T5: stop together with a tone change and a tick
    cyc(1'b0, 2, 1'b1, 1'b0);
    hold(2, 3, 1);
    cyc(1'b1, 8, 1'b0, 1'b1);
    idle(4, 8);
    check_take("T5");
    check("T5.lit0", {24'd0, cap_data[0][0]}, 32'h32);
    check("T5.nwr", cap_n[0], 2);

    // Randomized takes
    for (int t = 0; t < 4; t++) begin
      tn = $urandom_range(0, 3);
      cyc(1'b0, tn, 1'b1, 1'b0);
      len = $urandom_range(60, 160);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) tn = $urandom_range(0, 3);
        cyc($urandom_range(0, 2) == 0, tn, $urandom_range(0, 59) == 0, 1'b0);
      end
      cyc($urandom_range(0, 1) == 0, $urandom_range(0, 3), 1'b0, 1'b1);
      idle(4, tn);
      check_take($sformatf("RND%0d", t));
    end

    // Fill the large instance: one note per cycle
    cyc(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 270; i++) cyc(1'b1, 1 + (i % 2), 1'b0, 1'b0);
    cyc(1'b0, 1, 1'b0, 1'b1);
    idle(4, 1);
    check_take("FULL");
    check("FULL.big_full", {31'd0, full_b}, 32'd1);
    check("FULL.big_count", {24'd0, nc_b}, 32'd255);
    check("FULL.big_term_addr", cap_addr[0][255], 255);

    // T6: asynchronous reset while a write strobe is high
    cyc(1'b0, 5, 1'b1, 1'b0);
    hold(5, 2, 1);
    cyc(1'b0, 6, 1'b0, 1'b0);
    check("T6.pre_we_big", {31'd0, we_b}, 32'd1);
    check("T6.pre_we_small", {31'd0, we_s}, 32'd1);
    #1 rst = 1'b1;
    #1 check_all_zero("T6.async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0; m_busy[d] = 0; m_n[d] = 0; cap_n[d] = 0; m_rec[d] = 1'b0;
    end
    cyc(1'b0, 4, 1'b1, 1'b0);
    hold(4, 4, 1);
    cyc(1'b0, 4, 1'b0, 1'b1);
    idle(4, 4);
    check_take("T6");
    check("T6.restart_addr", cap_addr[0][0], 0);
    check("T6.restart_data", {24'd0, cap_data[0][0]}, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
